// File: rtl/sta_path_buf.sv
// Path capture buffer: stores an STA result burst, then replays the node list
// to a valid/ready consumer while flagging malformed paths in err.
module sta_path_buf #(
    parameter int         MAX_NODES = 16,
    parameter logic [3:0] SRC_NODE  = 4'd0,
    parameter logic [3:0] DST_NODE  = 4'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_delay,
    input  logic [3:0] in_node,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_node,
    output logic       out_last,
    output logic [4:0] path_len,
    output logic [7:0] path_delay,
    output logic [3:0] err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        REPLAY
    } state_t;

    localparam logic [4:0] MAX_LEN = 5'(MAX_NODES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  mem [16];
    logic [3:0]  rd_ptr;
    logic [15:0] visited;
    logic [4:0]  len_q;
    logic [7:0]  delay_q;
    logic [3:0]  err_q;

    logic start;
    logic store;
    logic drop;
    logic overrun;
    logic replay;
    logic last;
    logic accept;

    // The first CAPTURE cycle without in_valid already presents node 0,
    // so replay starts the cycle right after the burst.
    always_comb begin
        start     = (state == IDLE) && in_valid;
        store     = (state == CAPTURE) && in_valid && (len_q != MAX_LEN);
        drop      = (state == CAPTURE) && in_valid && (len_q == MAX_LEN);
        overrun   = (state == REPLAY) && in_valid;
        replay    = (state == REPLAY) || ((state == CAPTURE) && !in_valid);
        last      = replay && (5'(rd_ptr) == len_q - 5'd1);
        accept    = replay && out_ready;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (!in_valid) state_nxt = (accept && last) ? IDLE : REPLAY;
            end
            REPLAY: begin
                if (accept && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (start)      mem[0] <= in_node;
        else if (store) mem[len_q[3:0]] <= in_node;
    end

    // err[1] tracks the most recently stored node, so it is final once
    // the burst ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            visited <= '0;
            len_q   <= '0;
            delay_q <= '0;
            err_q   <= '0;
        end else begin
            if (start) begin
                len_q   <= 5'd1;
                delay_q <= in_delay;
                visited <= 16'b1 << in_node;
                rd_ptr  <= '0;
                err_q   <= {2'b00, in_node != DST_NODE, in_node != SRC_NODE};
            end
            if (store) begin
                len_q    <= len_q + 5'd1;
                visited  <= visited | (16'b1 << in_node);
                err_q[1] <= (in_node != DST_NODE);
                if (visited[in_node]) err_q[2] <= 1'b1;
            end
            if (drop || overrun) err_q[3] <= 1'b1;
            if (accept) rd_ptr <= last ? 4'd0 : rd_ptr + 4'd1;
        end
    end

    assign out_valid  = replay;
    assign out_node   = replay ? mem[rd_ptr] : 4'd0;
    assign out_last   = last;
    assign path_len   = len_q;
    assign path_delay = delay_q;
    assign err        = err_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sta_path_buf.sv
// Scoreboard bench for sta_path_buf: stimulus queues expected replays,
// a negedge monitor pops and compares every accepted output.
module tb_sta_path_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv   [2];
    logic [7:0] idl  [2];
    logic [3:0] inn  [2];
    logic       ordy [2];
    logic       ov   [2];
    logic [3:0] on   [2];
    logic       ol   [2];
    logic [4:0] pl   [2];
    logic [7:0] pd   [2];
    logic [3:0] er   [2];
    logic       bz   [2];

    sta_path_buf dut (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_delay(idl[0]), .in_node(inn[0]),
        .out_ready(ordy[0]), .out_valid(ov[0]), .out_node(on[0]),
        .out_last(ol[0]), .path_len(pl[0]), .path_delay(pd[0]),
        .err(er[0]), .busy(bz[0])
    );

    sta_path_buf #(.MAX_NODES(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_delay(idl[1]), .in_node(inn[1]),
        .out_ready(ordy[1]), .out_valid(ov[1]), .out_node(on[1]),
        .out_last(ol[1]), .path_len(pl[1]), .path_delay(pd[1]),
        .err(er[1]), .busy(bz[1])
    );

    typedef struct packed {
        logic [3:0] node;
        logic       last;
        logic [4:0] len;
        logic [7:0] dly;
        logic [3:0] err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad = 0;
    logic [3:0] pv [8];
    logic       hold_v [2];
    logic [3:0] hold_n [2];
    logic       hold_l [2];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            exp_t e;
            bit   got;
            if (hold_v[s] && !rst) begin
                check("hold_valid", 32'(ov[s]), 1);
                check("hold_node", 32'(on[s]), 32'(hold_n[s]));
                check("hold_last", 32'(ol[s]), 32'(hold_l[s]));
            end
            hold_v[s] = !rst && ov[s] && !ordy[s];
            hold_n[s] = on[s];
            hold_l[s] = ol[s];
            if (!rst && ov[s] && ordy[s]) begin
                got = 1'b0;
                if (s == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); got = 1'b1;
                end else if (s == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); got = 1'b1;
                end
                if (!got) begin
                    total++; bad++;
                    $display("FAIL unexpected_out dut%0d: node=%0d", s, on[s]);
                end else begin
                    check("node", 32'(on[s]), 32'(e.node));
                    check("last", 32'(ol[s]), 32'(e.last));
                    check("path_len", 32'(pl[s]), 32'(e.len));
                    check("path_delay", 32'(pd[s]), 32'(e.dly));
                    check("err", 32'(er[s]), 32'(e.err));
                end
            end
        end
    end

    task automatic setp(input int n, input logic [3:0] a0, a1, a2, a3,
                        input logic [3:0] a4, a5);
        pv[0] = a0; pv[1] = a1; pv[2] = a2;
        pv[3] = a3; pv[4] = a4; pv[5] = a5;
    endtask

    task automatic push(input int s, input exp_t e);
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic expect_path(input int s, input int n,
                               input logic [7:0] d, input logic [3:0] e);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            x.node = pv[i];
            x.last = (i == n - 1);
            x.len  = 5'(n);
            x.dly  = d;
            x.err  = e;
            push(s, x);
        end
    endtask

    // Later burst cycles carry a different delay to prove only the first is sampled.
    task automatic burst(input int s, input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            iv[s]  = 1'b1;
            inn[s] = pv[i];
            idl[s] = (i == 0) ? d : ~d;
        end
        @(posedge clk); #1;
        iv[s]  = 1'b0;
        inn[s] = 4'd0;
    endtask

    task automatic wait_done(input int s);
        int k = 0;
        int sz;
        sz = (s == 0) ? q0.size() : q1.size();
        while (k < 60 && (bz[s] || sz != 0)) begin
            @(posedge clk); #1;
            k++;
            sz = (s == 0) ? q0.size() : q1.size();
        end
        check("drain_busy", 32'(bz[s]), 0);
        check("drain_queue", 32'(sz), 0);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_valid"}, 32'(ov[0]), 0);
        check({nm, "_node"}, 32'(on[0]), 0);
        check({nm, "_last"}, 32'(ol[0]), 0);
        check({nm, "_len"}, 32'(pl[0]), 0);
        check({nm, "_delay"}, 32'(pd[0]), 0);
        check({nm, "_err"}, 32'(er[0]), 0);
        check({nm, "_busy"}, 32'(bz[0]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        exp_t x;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; idl[s] = 8'd0; inn[s] = 4'd0; ordy[s] = 1'b1;
            hold_v[s] = 1'b0; hold_n[s] = 4'd0; hold_l[s] = 1'b0;
        end
        #1;
        check_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // basic replay, then a back-to-back burst
        setp(4, 4'd0, 4'd3, 4'd7, 4'd1, 4'd0, 4'd0);
        expect_path(0, 4, 8'd42, 4'b0000);
        burst(0, 4, 8'd42);
        repeat (3) @(posedge clk);
        #1;
        check("c4_busy", 32'(bz[0]), 1);
        check("c4_valid", 32'(ov[0]), 1);
        check("c4_last", 32'(ol[0]), 1);
        setp(2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
        expect_path(0, 2, 8'd9, 4'b0000);
        burst(0, 2, 8'd9);
        wait_done(0);

        // toggling ready: 4 nodes over 7 cycles
        setp(4, 4'd0, 4'd3, 4'd7, 4'd1, 4'd0, 4'd0);
        expect_path(0, 4, 8'd42, 4'b0000);
        burst(0, 4, 8'd42);
        for (int k = 0; k < 7; k++) begin
            ordy[0] = (k % 2 == 0);
            if (k == 6) check("toggle_c7_busy", 32'(bz[0]), 1);
            @(posedge clk); #1;
        end
        check("toggle_c8_busy", 32'(bz[0]), 0);
        ordy[0] = 1'b1;
        wait_done(0);

        // error flags
        setp(3, 4'd2, 4'd5, 4'd1, 4'd0, 4'd0, 4'd0);
        expect_path(0, 3, 8'd5, 4'b0001);
        burst(0, 3, 8'd5);
        wait_done(0);
        setp(4, 4'd0, 4'd5, 4'd5, 4'd1, 4'd0, 4'd0);
        expect_path(0, 4, 8'd6, 4'b0100);
        burst(0, 4, 8'd6);
        wait_done(0);
        setp(2, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0);
        expect_path(0, 2, 8'd200, 4'b0010);
        burst(0, 2, 8'd200);
        wait_done(0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_len", 32'(pl[0]), 2);
        check("idle_hold_delay", 32'(pd[0]), 200);
        check("idle_hold_err", 32'(er[0]), 2);

        // single node burst
        setp(1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        expect_path(0, 1, 8'd17, 4'b0010);
        burst(0, 1, 8'd17);
        wait_done(0);

        // overrun pulse during replay
        x = '{4'd0, 1'b0, 5'd4, 8'd42, 4'b0000}; push(0, x);
        x = '{4'd3, 1'b0, 5'd4, 8'd42, 4'b0000}; push(0, x);
        x = '{4'd7, 1'b0, 5'd4, 8'd42, 4'b1000}; push(0, x);
        x = '{4'd1, 1'b1, 5'd4, 8'd42, 4'b1000}; push(0, x);
        setp(4, 4'd0, 4'd3, 4'd7, 4'd1, 4'd0, 4'd0);
        burst(0, 4, 8'd42);
        @(posedge clk); #1;
        iv[0] = 1'b1; inn[0] = 4'd9;
        @(posedge clk); #1;
        iv[0] = 1'b0; inn[0] = 4'd0;
        wait_done(0);
        check("overrun_len", 32'(pl[0]), 4);

        // overflow on a 4-deep buffer
        setp(6, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1);
        expect_path(1, 4, 8'd77, 4'b1010);
        burst(1, 6, 8'd77);
        wait_done(1);
        check("ovf_len", 32'(pl[1]), 4);

        // reset on the second replay cycle
        x = '{4'd0, 1'b0, 5'd4, 8'd42, 4'b0000}; push(0, x);
        setp(4, 4'd0, 4'd3, 4'd7, 4'd1, 4'd0, 4'd0);
        burst(0, 4, 8'd42);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        setp(2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
        expect_path(0, 2, 8'd3, 4'b0000);
        burst(0, 2, 8'd3);
        wait_done(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
